// File: rtl/set_sched_pkg.sv
// Shared types and widths for the SET job scheduler: the buffered job record
// and the scheduler state encoding.
package set_sched_pkg;

    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int MODE_W    = 2;
    localparam int COUNT_W   = 8;
    localparam int JOB_TAG_W = 4;

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
        logic [JOB_TAG_W-1:0] tag;
    } job_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESULT
    } state_e;

    function automatic job_t make_job(input logic [CENTRAL_W-1:0] central,
                                      input logic [RADIUS_W-1:0]  radius,
                                      input logic [MODE_W-1:0]    mode,
                                      input logic [JOB_TAG_W-1:0] tag);
        job_t j;
        j.central = central;
        j.radius  = radius;
        j.mode    = mode;
        j.tag     = tag;
        return j;
    endfunction

endpackage

// File: rtl/set_job_sched_if.sv
// Bundles the job input, SET operand/result and result output handshakes.
// The scheduler takes the slave view; its environment takes the master view.
interface set_job_sched_if
    import set_sched_pkg::*;
#(
    parameter int TAG_W = JOB_TAG_W
);

    logic                 job_valid;
    logic                 job_ready;
    logic [CENTRAL_W-1:0] job_central;
    logic [RADIUS_W-1:0]  job_radius;
    logic [MODE_W-1:0]    job_mode;
    logic [TAG_W-1:0]     job_tag;

    logic                 set_en;
    logic [CENTRAL_W-1:0] set_central;
    logic [RADIUS_W-1:0]  set_radius;
    logic [MODE_W-1:0]    set_mode;
    logic                 set_busy;
    logic                 set_valid;
    logic [COUNT_W-1:0]   set_candidate;

    logic                 res_valid;
    logic                 res_ready;
    logic [COUNT_W-1:0]   res_count;
    logic [TAG_W-1:0]     res_tag;
    logic                 res_err;

    modport slave (
        input  job_valid, job_central, job_radius, job_mode, job_tag,
        input  set_busy, set_valid, set_candidate,
        input  res_ready,
        output job_ready,
        output set_en, set_central, set_radius, set_mode,
        output res_valid, res_count, res_tag, res_err
    );

    modport master (
        output job_valid, job_central, job_radius, job_mode, job_tag,
        output set_busy, set_valid, set_candidate,
        output res_ready,
        input  job_ready,
        input  set_en, set_central, set_radius, set_mode,
        input  res_valid, res_count, res_tag, res_err
    );

endinterface

// File: rtl/set_job_fifo.sv
// Synchronous FIFO of job records. A push is refused while full, even when a
// pop happens in the same cycle; pointers wrap naturally since DEPTH is 2^n.
module set_job_fifo
    import set_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  job_t wdata_i,
    input  logic pop_i,
    output job_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    job_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are live, so stale data is never observable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/set_job_sched.sv
// Job scheduler in front of the SET coverage counter: buffers jobs, issues
// one at a time, returns tagged results. SET_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module set_job_sched
    import set_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = JOB_TAG_W
`ifdef SET_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 80
`endif
) (
    input  logic              clk,
    input  logic              rst,
    set_job_sched_if.slave    bus
);

    state_e             state_q, state_d;
    job_t               hold_q, hold_d;
    logic [COUNT_W-1:0] res_count_q, res_count_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;

    job_t               fifo_wdata;
    job_t               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

`ifdef SET_SCHED_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               res_err_q, res_err_d;
`endif

    assign fifo_wdata = make_job(bus.job_central, bus.job_radius, bus.job_mode,
                                 JOB_TAG_W'(bus.job_tag));

    set_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.job_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every variable gets its hold value before the case so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        res_count_d = res_count_q;
        res_tag_d   = res_tag_q;
        fifo_pop    = 1'b0;
`ifdef SET_SCHED_TIMEOUT_EN
        tmo_d       = tmo_q;
        res_err_d   = res_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !bus.set_busy) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_head;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef SET_SCHED_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end

            S_WAIT: begin
                if (bus.set_valid) begin
                    res_count_d = bus.set_candidate;
                    res_tag_d   = TAG_W'(hold_q.tag);
                    state_d     = S_RESULT;
`ifdef SET_SCHED_TIMEOUT_EN
                    res_err_d   = 1'b0;
`endif
                end
`ifdef SET_SCHED_TIMEOUT_EN
                // SET never answered: report an empty, flagged result for this tag.
                else if (tmo_q == TMO_LAST) begin
                    res_count_d = '0;
                    res_tag_d   = TAG_W'(hold_q.tag);
                    res_err_d   = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end

            S_RESULT: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            res_count_q <= '0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            res_count_q <= res_count_d;
            res_tag_q   <= res_tag_d;
        end
    end

`ifdef SET_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '0;
            res_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            res_err_q <= res_err_d;
        end
    end

    assign bus.res_err = res_err_q;
`else
    assign bus.res_err = 1'b0;
`endif

    // All outputs come from registers; job_ready depends only on the FIFO count.
    assign bus.job_ready   = !fifo_full;
    assign bus.set_en      = (state_q == S_ISSUE);
    assign bus.set_central = hold_q.central;
    assign bus.set_radius  = hold_q.radius;
    assign bus.set_mode    = hold_q.mode;
    assign bus.res_valid   = (state_q == S_RESULT);
    assign bus.res_count   = res_count_q;
    assign bus.res_tag     = res_tag_q;

endmodule
